// File: rtl/fpu_alu_pkg.sv
// Shared opcode type for the FPU datapath: fp_alu and its issue sequencer.
package fpu_alu_pkg;

  typedef enum logic [3:0] {
    FPU_ADD     = 4'd0,
    FPU_SUB     = 4'd1,
    FPU_MUL     = 4'd2,
    FPU_DIV     = 4'd3,
    FPU_SQRT    = 4'd4,
    FPU_FMADD   = 4'd5,
    FPU_FMSUB   = 4'd6,
    FPU_MIN     = 4'd7,
    FPU_MAX     = 4'd8,
    FPU_SGNJ    = 4'd9,
    FPU_CMP     = 4'd10,
    FPU_CVT_W_S = 4'd11,
    FPU_CVT_S_W = 4'd12
  } fpu_op_t;

  // Quiet canonical NaN returned when an op has to be abandoned.
  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, fp_alu and writeback channels of the FPU issue sequencer.
interface fpu_issue_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
);

  logic                        req_valid;
  logic                        req_ready;
  fpu_alu_pkg::fpu_op_t        req_op;
  logic [DATA_WIDTH-1:0]       req_a;
  logic [DATA_WIDTH-1:0]       req_b;
  logic [DATA_WIDTH-1:0]       req_c;
  logic [TAG_WIDTH-1:0]        req_tag;

  logic                        alu_start;
  fpu_alu_pkg::fpu_op_t        alu_op;
  logic [DATA_WIDTH-1:0]       alu_a;
  logic [DATA_WIDTH-1:0]       alu_b;
  logic [DATA_WIDTH-1:0]       alu_c;
  logic [DATA_WIDTH-1:0]       alu_result;
  logic                        alu_result_valid;
  logic                        alu_busy;

  logic                        wb_valid;
  logic                        wb_ready;
  logic [DATA_WIDTH-1:0]       wb_data;
  logic [TAG_WIDTH-1:0]        wb_tag;
  logic                        wb_timeout;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_tag,
    output req_ready,
    output alu_start, alu_op, alu_a, alu_b, alu_c,
    input  alu_result, alu_result_valid, alu_busy,
    output wb_valid, wb_data, wb_tag, wb_timeout,
    input  wb_ready
  );

  // Dispatch, fp_alu and writeback side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_tag,
    input  req_ready,
    input  alu_start, alu_op, alu_a, alu_b, alu_c,
    output alu_result, alu_result_valid, alu_busy,
    input  wb_valid, wb_data, wb_tag, wb_timeout,
    output wb_ready
  );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer in front of fp_alu: one op in flight, latched operands,
// watchdog on DIV/SQRT, and a one-entry result register toward writeback.
module fpu_issue_ctrl
  import fpu_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_issue_ctrl_if.slave      bus,
  output logic [CNT_WIDTH-1:0] ops_done
);

  localparam int unsigned WDOG_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] NAN_RESULT = DATA_WIDTH'(FP32_CANON_NAN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [WDOG_WIDTH-1:0] wdog;

  logic slot_free_c;
  logic op_multi_c;
  logic accept_c;
  logic drain_c;
  logic capture_c;
  logic cap_real_c;

  assign slot_free_c   = !bus.wb_valid || bus.wb_ready;
  assign op_multi_c    = (bus.alu_op == FPU_DIV) || (bus.alu_op == FPU_SQRT);
  assign bus.req_ready = rst_n && (state == IDLE) && slot_free_c;
  assign bus.alu_start = rst_n && (state == ISSUE) && !bus.alu_busy;
  assign accept_c      = bus.req_valid && bus.req_ready;
  assign drain_c       = bus.wb_valid && bus.wb_ready;

  // Capture decision; a capture without a valid ALU result is a forced NaN.
  always_comb begin
    capture_c  = 1'b0;
    cap_real_c = 1'b0;
    case (state)
      ISSUE: begin
        if (bus.alu_start && !op_multi_c) begin
          capture_c  = 1'b1;
          cap_real_c = bus.alu_result_valid;
        end
      end
      WAIT: begin
        capture_c  = bus.alu_result_valid || (wdog == WDOG_LIMIT);
        cap_real_c = bus.alu_result_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tag_q          <= '0;
      wdog           <= '0;
      bus.alu_op     <= FPU_ADD;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_c      <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_data    <= '0;
      bus.wb_tag     <= '0;
      bus.wb_timeout <= 1'b0;
      ops_done       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            bus.alu_op <= bus.req_op;
            bus.alu_a  <= bus.req_a;
            bus.alu_b  <= bus.req_b;
            bus.alu_c  <= bus.req_c;
            tag_q      <= bus.req_tag;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.alu_start) begin
            if (op_multi_c) begin
              wdog  <= '0;
              state <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT: begin
          wdog <= wdog + WDOG_WIDTH'(1);
          if (capture_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A capture may land on the same edge the slot drains: no bubble.
      if (capture_c) begin
        bus.wb_valid   <= 1'b1;
        bus.wb_data    <= cap_real_c ? bus.alu_result : NAN_RESULT;
        bus.wb_timeout <= !cap_real_c;
        bus.wb_tag     <= tag_q;
      end else if (drain_c) begin
        bus.wb_valid <= 1'b0;
      end

      if (drain_c) begin
        ops_done <= ops_done + CNT_WIDTH'(1);
      end
    end
  end

endmodule
